uart_echo_fifo: RTL and testbench

Buffered, mode-selectable echo stage placed between `uart_rx` and `uart_tx` in loopback designs, replacing the direct valid/ready wire-through. Accepted receive bytes enter a parametrised FIFO. Each byte is then echoed unchanged, upper-cased, held until a line terminator arrives, or discarded, depending on `mode`. It also exports fill level and byte counters for LED/debug use.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 59 +++++
 rtl/uart_echo_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_echo_fifo.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo path.
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO    = 2'd0,
    MODE_UPPER   = 2'd1,
    MODE_LINE    = 2'd2,
    MODE_DISCARD = 2'd3
  } uart_echo_mode_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lower-case ASCII letters become upper case, everything else is untouched.
  function automatic logic [7:0] ascii_to_upper(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if ((b >= 8'h61) && (b <= 8'h7A)) begin
      r = b & 8'hDF;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and an occupancy count that
// is the sole source of the full/empty decision.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == {LW{1'b0}});
  assign level = level_r;

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered echo stage between uart_rx and uart_tx: stores received bytes,
// releases them according to mode (echo, upper-case, line-held, discard)
// and keeps receive/drop statistics.
module uart_echo_fifo import uart_pkg::*; #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] LINE_TERM = ASCII_CR,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  input  logic [7:0]             s_axis_tdata,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [7:0]             m_axis_tdata,
  input  logic                   m_axis_tready,
  input  logic [1:0]             mode,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_WIDTH-1:0]   rx_count,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int              LW      = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);

  uart_echo_mode_e      mode_s;
  logic                 s_hs_s;
  logic                 m_hs_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic [7:0]           rd_data_s;
  logic [7:0]           tdata_s;
  logic [LW-1:0]        level_s;
  logic [LW-1:0]        level_next_s;
  logic [LW-1:0]        release_r;
  logic [LW-1:0]        release_next_s;
  logic                 tready_r;
  logic                 tready_next_s;
  logic                 tvalid_r;
  logic [CNT_WIDTH-1:0] rx_count_r;
  logic [CNT_WIDTH-1:0] drop_count_r;

  assign mode_s = uart_echo_mode_e'(mode);
  assign s_hs_s = s_axis_tvalid && tready_r;
  assign m_hs_s = tvalid_r && m_axis_tready;
  assign push_s = s_hs_s && (mode_s != MODE_DISCARD) && !full_s;
  assign pop_s  = m_hs_s && !empty_s;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (s_axis_tdata),
    .rdata (rd_data_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Occupancy after this edge, used to steer release and ready.
  always_comb begin
    level_next_s = level_s;
    if (push_s && !pop_s) begin
      level_next_s = level_s + LW'(1'b1);
    end else if (!push_s && pop_s) begin
      level_next_s = level_s - LW'(1'b1);
    end else begin
      level_next_s = level_s;
    end
  end

  // Release count: everything stored is releasable except in LINE mode,
  // where bytes wait for the terminator or for a full-FIFO forced flush.
  always_comb begin
    release_next_s = release_r;
    case (mode_s)
      MODE_LINE: begin
        if (push_s && (s_axis_tdata == LINE_TERM)) begin
          release_next_s = level_next_s;
        end else if ((level_next_s == DEPTH_L) && (release_r == {LW{1'b0}})) begin
          release_next_s = DEPTH_L;
        end else if (pop_s) begin
          release_next_s = release_r - LW'(1'b1);
        end else begin
          release_next_s = release_r;
        end
      end
      default: release_next_s = level_next_s;
    endcase
  end

  // Ready for the next cycle: DISCARD always accepts, otherwise not when full.
  always_comb begin
    tready_next_s = 1'b0;
    if (mode_s == MODE_DISCARD) begin
      tready_next_s = 1'b1;
    end else begin
      tready_next_s = (level_next_s != DEPTH_L);
    end
  end

  // Handshake and release state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tready_r  <= 1'b0;
      tvalid_r  <= 1'b0;
      release_r <= {LW{1'b0}};
    end else begin
      tready_r  <= tready_next_s;
      tvalid_r  <= (release_next_s != {LW{1'b0}});
      release_r <= release_next_s;
    end
  end

  // Statistics: every slave handshake counts, discarded ones also as drops.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_count_r   <= {CNT_WIDTH{1'b0}};
      drop_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (s_hs_s) begin
        rx_count_r <= rx_count_r + CNT_WIDTH'(1'b1);
      end
      if (s_hs_s && (mode_s == MODE_DISCARD)) begin
        drop_count_r <= drop_count_r + CNT_WIDTH'(1'b1);
      end
    end
  end

  // Output transform applied to the head-of-FIFO byte.
  always_comb begin
    tdata_s = rd_data_s;
    if (mode_s == MODE_UPPER) begin
      tdata_s = ascii_to_upper(rd_data_s);
    end else begin
      tdata_s = rd_data_s;
    end
  end

  assign s_axis_tready = tready_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_s;
  assign level         = level_s;
  assign rx_count      = rx_count_r;
  assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Testbench for uart_echo_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uart_echo_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = 5;
  localparam int CW    = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [7:0]    s_axis_tdata = 8'h00;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tready = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [LW-1:0] level;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]    q[$];
  int            rel = 0;
  logic [CW-1:0] m_rx = '0;
  logic [CW-1:0] m_drop = '0;
  bit            started = 1'b0;

  uart_echo_fifo #(.DEPTH(DEPTH), .LINE_TERM(8'h0D), .CNT_WIDTH(CW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .mode          (mode),
    .level         (level),
    .rx_count      (rx_count),
    .drop_count    (drop_count)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    q.delete();
    rel = 0;
    m_rx = '0;
    m_drop = '0;
    started = 1'b0;
  endfunction

  function automatic logic exp_ready();
    return started && ((mode == 2'd3) || (q.size() < DEPTH));
  endfunction

  function automatic logic exp_valid();
    return rel != 0;
  endfunction

  function automatic logic [7:0] exp_data();
    logic [7:0] b;
    b = q[0];
    if (mode == 2'd1 && b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
    return b;
  endfunction

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // return at the next falling edge. No checks in here.
  task automatic tick(input logic sv, input logic [7:0] sd, input logic mr);
    logic rdy, vld, term;
    int old_rel;
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    m_axis_tready = mr;
    rdy = exp_ready();
    vld = exp_valid();
    old_rel = rel;
    term = 1'b0;
    @(posedge aclk);
    if (vld && mr) void'(q.pop_front());
    if (sv && rdy) begin
      m_rx = m_rx + 1'b1;
      if (mode == 2'd3) m_drop = m_drop + 1'b1;
      else begin
        q.push_back(sd);
        term = (sd == 8'h0D);
      end
    end
    if (mode != 2'd2) rel = q.size();
    else if (term) rel = q.size();
    else if (q.size() == DEPTH && old_rel == 0) rel = DEPTH;
    else if (vld && mr) rel = old_rel - 1;
    else rel = old_rel;
    if (aresetn) started = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    model_reset();
    repeat (2) @(negedge aclk);
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %0b want 0", s_axis_tready); end
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); end
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_vec++; if (rx_count !== 16'd0) begin n_err++; $display("FAIL reset_rx: got %0d want 0", rx_count); end
    n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    aresetn = 1'b1;
    #1;
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_release_tready: got %0b want 0", s_axis_tready); end
    tick(1'b0, 8'h00, 1'b0);
    n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL reset_first_clk_tready: got %0b want 1", s_axis_tready); end
  endtask

  task automatic test_echo();
    logic [CW-1:0] rx0;
    mode = 2'd0;
    rx0 = m_rx;
    tick(1'b1, 8'h41, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h41) begin n_err++; $display("FAIL echo_b0: got v=%0b d=%h want v=1 d=41", m_axis_tvalid, m_axis_tdata); end
    tick(1'b1, 8'h62, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h62) begin n_err++; $display("FAIL echo_b1: got v=%0b d=%h want v=1 d=62", m_axis_tvalid, m_axis_tdata); end
    tick(1'b0, 8'h00, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL echo_empty: got v=%0b want 0", m_axis_tvalid); end
    n_vec++; if (rx_count !== rx0 + 16'd2) begin n_err++; $display("FAIL echo_rx: got %0d want %0d", rx_count, rx0 + 16'd2); end
  endtask

  task automatic test_upper();
    logic [7:0] din  [4];
    logic [7:0] dout [4];
    din  = '{8'h61, 8'h7A, 8'h5B, 8'h31};
    dout = '{8'h41, 8'h5A, 8'h5B, 8'h31};
    mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, din[i], 1'b1);
      n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== dout[i]) begin n_err++; $display("FAIL upper_%0d: got v=%0b d=%h want v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, dout[i]); end
    end
    tick(1'b0, 8'h00, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL upper_empty: got v=%0b want 0", m_axis_tvalid); end
  endtask

  task automatic test_line();
    logic [7:0] exp [3];
    exp = '{8'h68, 8'h69, 8'h0D};
    mode = 2'd2;
    tick(1'b1, 8'h68, 1'b1);
    tick(1'b1, 8'h69, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL line_held: got v=%0b want 0", m_axis_tvalid); end
    n_vec++; if (level !== 5'd2) begin n_err++; $display("FAIL line_level: got %0d want 2", level); end
    tick(1'b1, 8'h0D, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp[i]) begin n_err++; $display("FAIL line_out_%0d: got v=%0b d=%h want v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, exp[i]); end
      tick(1'b0, 8'h00, 1'b1);
    end
    n_vec++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL line_done: got v=%0b lvl=%0d want v=0 lvl=0", m_axis_tvalid, level); end
  endtask

  task automatic test_line_overflow();
    logic [7:0] arr [16];
    mode = 2'd2;
    for (int i = 0; i < 16; i++) begin
      arr[i] = 8'($urandom_range(0, 255));
      if (arr[i] == 8'h0D) arr[i] = 8'h20;
      tick(1'b1, arr[i], 1'b0);
    end
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL ovf_tready: got %0b want 0", s_axis_tready); end
    n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", level); end
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== arr[i]) begin n_err++; $display("FAIL ovf_out_%0d: got v=%0b d=%h want v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, arr[i]); end
      tick(1'b0, 8'h00, 1'b1);
      if (i == 0) begin
        n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL ovf_tready_after_pop: got %0b want 1", s_axis_tready); end
      end
    end
    n_vec++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL ovf_done: got v=%0b lvl=%0d want v=0 lvl=0", m_axis_tvalid, level); end
  endtask

  task automatic test_discard();
    logic [CW-1:0] rx0, d0;
    mode = 2'd3;
    rx0 = m_rx;
    d0 = m_drop;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL discard_tready_%0d: got %0b want 1", i, s_axis_tready); end
      tick(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      n_vec++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL discard_out_%0d: got v=%0b lvl=%0d want v=0 lvl=0", i, m_axis_tvalid, level); end
    end
    n_vec++; if (drop_count !== d0 + 16'd5) begin n_err++; $display("FAIL discard_drop: got %0d want %0d", drop_count, d0 + 16'd5); end
    n_vec++; if (rx_count !== rx0 + 16'd5) begin n_err++; $display("FAIL discard_rx: got %0d want %0d", rx_count, rx0 + 16'd5); end
  endtask

  task automatic test_random();
    int budget;
    logic [7:0] sd;
    for (int seg = 0; seg < 8; seg++) begin
      mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < 60; c++) begin
        sd = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
        tick(1'($urandom_range(0, 1)), sd, ($urandom_range(0, 3) != 0));
        n_vec++; if (s_axis_tready !== exp_ready()) begin n_err++; $display("FAIL rnd_tready: got %0b want %0b", s_axis_tready, exp_ready()); end
        n_vec++; if (m_axis_tvalid !== exp_valid()) begin n_err++; $display("FAIL rnd_tvalid: got %0b want %0b", m_axis_tvalid, exp_valid()); end
        n_vec++; if (level !== LW'(q.size())) begin n_err++; $display("FAIL rnd_level: got %0d want %0d", level, q.size()); end
        n_vec++; if (rx_count !== m_rx || drop_count !== m_drop) begin n_err++; $display("FAIL rnd_counts: got rx=%0d drop=%0d want rx=%0d drop=%0d", rx_count, drop_count, m_rx, m_drop); end
        if (exp_valid()) begin
          n_vec++; if (m_axis_tdata !== exp_data()) begin n_err++; $display("FAIL rnd_tdata: got %h want %h", m_axis_tdata, exp_data()); end
        end
      end
      budget = 200;
      while (q.size() > 0 && budget > 0) begin
        if (mode == 2'd2 && rel == 0) tick(1'b1, 8'h0D, 1'b1);
        else tick(1'b0, 8'h00, 1'b1);
        budget--;
      end
      n_vec++; if (level !== 5'd0 || q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got lvl=%0d want 0 (model %0d)", level, q.size()); end
    end
  endtask

  task automatic test_reset_midstream();
    mode = 2'd0;
    tick(1'b1, 8'hA1, 1'b0);
    tick(1'b1, 8'hA2, 1'b0);
    tick(1'b1, 8'hA3, 1'b0);
    n_vec++; if (level !== 5'd3 || m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL mid_pre: got lvl=%0d v=%0b want lvl=3 v=1", level, m_axis_tvalid); end
    s_axis_tvalid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    n_vec++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_hs: got rdy=%0b v=%0b want 0 0", s_axis_tready, m_axis_tvalid); end
    n_vec++; if (level !== 5'd0 || rx_count !== 16'd0 || drop_count !== 16'd0) begin n_err++; $display("FAIL mid_state: got lvl=%0d rx=%0d drop=%0d want 0 0 0", level, rx_count, drop_count); end
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    tick(1'b0, 8'h00, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0 || s_axis_tready !== 1'b1) begin n_err++; $display("FAIL mid_after: got v=%0b lvl=%0d rdy=%0b want 0 0 1", m_axis_tvalid, level, s_axis_tready); end
    tick(1'b1, 8'h55, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h55) begin n_err++; $display("FAIL mid_fresh: got v=%0b d=%h want v=1 d=55", m_axis_tvalid, m_axis_tdata); end
    tick(1'b0, 8'h00, 1'b1);
    n_vec++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL mid_stale: got v=%0b lvl=%0d want 0 0", m_axis_tvalid, level); end
  endtask

  initial begin
    @(negedge aclk);
    test_reset();
    test_echo();
    test_upper();
    test_line();
    test_line_overflow();
    test_discard();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
